axi_write_sequencer: RTL and testbench

AXI_WRITE_SEQUENCER -- requirements
Module: axi_write_sequencer

---
 rtl/axi_trans_pkg.sv | 26 ++
 rtl/axi_write_sequencer.sv | 174 +++++++++++++++++
 tb/tb_axi_write_sequencer.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_trans_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_trans_pkg
// Description : Shared AXI constants, sequencer state encoding and size helper
// Revision    : 1.0 - initial release
// ============================================================================
package axi_trans_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_B = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    // AXI AxSIZE encoding: log2 of the number of bytes per beat
    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : axi_write_sequencer
// Description : Issues a table of single-beat AXI4 writes, one outstanding at
//               a time, on a rising edge of the start request. DATA_WIDTH is
//               32 or 64.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_write_sequencer
    import axi_trans_pkg::*;
#(
    parameter int NUM_WRITES    = 3,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 4,
    parameter bit STOP_ON_ERROR = 1'b1
) (
    input  logic                               m00_axi_aclk,
    input  logic                               m00_axi_aresetn,
    input  logic                               m00_axi_init_axi_txn,
    input  logic [NUM_WRITES*ADDR_WIDTH-1:0]   seq_addr,
    input  logic [NUM_WRITES*DATA_WIDTH-1:0]   seq_data,
    input  logic [$clog2(NUM_WRITES+1)-1:0]    seq_count,
    output logic [ID_WIDTH-1:0]                m00_axi_awid,
    output logic [ADDR_WIDTH-1:0]              m00_axi_awaddr,
    output logic                               m00_axi_awvalid,
    output logic [7:0]                         m00_axi_awlen,
    output logic [2:0]                         m00_axi_awsize,
    output logic [1:0]                         m00_axi_awburst,
    output logic                               m00_axi_awlock,
    output logic [3:0]                         m00_axi_awcache,
    output logic [2:0]                         m00_axi_awprot,
    output logic [3:0]                         m00_axi_awqos,
    input  logic                               m00_axi_awready,
    output logic [DATA_WIDTH-1:0]              m00_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]            m00_axi_wstrb,
    output logic                               m00_axi_wlast,
    output logic                               m00_axi_wvalid,
    input  logic                               m00_axi_wready,
    input  logic [ID_WIDTH-1:0]                m00_axi_bid,
    input  logic [1:0]                         m00_axi_bresp,
    input  logic                               m00_axi_bvalid,
    output logic                               m00_axi_bready,
    output logic                               busy,
    output logic                               done,
    output logic                               error
);

    localparam int CW = $clog2(NUM_WRITES + 1);

    seq_state_t       r_state;
    logic             r_init_d;
    logic [CW-1:0]    r_idx;
    logic [CW-1:0]    r_count;

    logic                  w_init_rise;
    logic [CW-1:0]         w_count_clamped;
    logic [CW-1:0]         w_idx_inc;
    logic [CW-1:0]         w_load_idx;
    logic [ADDR_WIDTH-1:0] w_addr_sel;
    logic [DATA_WIDTH-1:0] w_data_sel;
    logic                  w_aw_done;
    logic                  w_w_done;
    logic                  w_b_hs;
    logic                  w_b_bad;
    logic                  w_err_next;

    assign m00_axi_awlen   = 8'd0;
    assign m00_axi_awsize  = axi_size(DATA_WIDTH);
    assign m00_axi_awburst = BURST_INCR;
    assign m00_axi_awlock  = 1'b0;
    assign m00_axi_awcache = CACHE_DEFAULT;
    assign m00_axi_awprot  = 3'd0;
    assign m00_axi_awqos   = 4'd0;
    assign m00_axi_wstrb   = '1;
    assign m00_axi_wlast   = 1'b1;

    assign w_init_rise     = m00_axi_init_axi_txn && !r_init_d;
    assign w_count_clamped = (seq_count > CW'(NUM_WRITES)) ? CW'(NUM_WRITES) : seq_count;
    assign w_idx_inc       = r_idx + CW'(1);

    // The entry loaded on entering ISSUE: 0 from IDLE, the next index from WAIT_B
    assign w_load_idx = (r_state == IDLE) ? '0 : w_idx_inc;
    assign w_addr_sel = seq_addr[w_load_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data_sel = seq_data[w_load_idx*DATA_WIDTH +: DATA_WIDTH];

    // A channel counts as complete once its valid has dropped or is being accepted now
    assign w_aw_done  = !m00_axi_awvalid || m00_axi_awready;
    assign w_w_done   = !m00_axi_wvalid  || m00_axi_wready;
    assign w_b_hs     = m00_axi_bvalid && m00_axi_bready;
    assign w_b_bad    = (m00_axi_bresp != RESP_OKAY) || (m00_axi_bid != m00_axi_awid);
    assign w_err_next = error || w_b_bad;

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            r_state         <= IDLE;
            // Starting at 1 makes a request already high at reset release look like no edge
            r_init_d        <= 1'b1;
            r_idx           <= '0;
            r_count         <= '0;
            m00_axi_awvalid <= 1'b0;
            m00_axi_wvalid  <= 1'b0;
            m00_axi_bready  <= 1'b0;
            m00_axi_awaddr  <= '0;
            m00_axi_wdata   <= '0;
            m00_axi_awid    <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            r_init_d <= m00_axi_init_axi_txn;
            done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_init_rise) begin
                        r_count <= w_count_clamped;
                        r_idx   <= '0;
                        error   <= 1'b0;
                        if (w_count_clamped == '0) begin
                            r_state <= FINISH;
                        end else begin
                            r_state         <= ISSUE;
                            busy            <= 1'b1;
                            m00_axi_awvalid <= 1'b1;
                            m00_axi_wvalid  <= 1'b1;
                            m00_axi_awaddr  <= w_addr_sel;
                            m00_axi_wdata   <= w_data_sel;
                            m00_axi_awid    <= ID_WIDTH'(w_load_idx);
                        end
                    end
                end
                ISSUE: begin
                    if (m00_axi_awready) begin
                        m00_axi_awvalid <= 1'b0;
                    end
                    if (m00_axi_wready) begin
                        m00_axi_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_state        <= WAIT_B;
                        m00_axi_bready <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (w_b_hs) begin
                        m00_axi_bready <= 1'b0;
                        error          <= w_err_next;
                        r_idx          <= w_idx_inc;
                        if ((w_idx_inc == r_count) || (w_err_next && STOP_ON_ERROR)) begin
                            r_state <= FINISH;
                            busy    <= 1'b0;
                        end else begin
                            r_state         <= ISSUE;
                            m00_axi_awvalid <= 1'b1;
                            m00_axi_wvalid  <= 1'b1;
                            m00_axi_awaddr  <= w_addr_sel;
                            m00_axi_wdata   <= w_data_sel;
                            m00_axi_awid    <= ID_WIDTH'(w_load_idx);
                        end
                    end
                end
                FINISH: begin
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_write_sequencer
// Description : Directed bench; three sequencer instances share stimulus:
//               [0] defaults, [1] STOP_ON_ERROR=0, [2] ID_WIDTH=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_write_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init;
    logic        awready;
    logic        wready;
    logic [95:0] seq_addr;
    logic [95:0] seq_data;
    logic [1:0]  seq_count;
    int          bad_entry;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_addr [3];
    logic [31:0] exp_data [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int IDW = (g == 2) ? 1 : 4;
        localparam bit SOE = (g == 1) ? 1'b0 : 1'b1;

        logic [IDW-1:0] awid;
        logic [IDW-1:0] bid;
        logic [31:0]    awaddr;
        logic [31:0]    wdata;
        logic [7:0]     awlen;
        logic [2:0]     awsize;
        logic [1:0]     awburst;
        logic           awlock;
        logic [3:0]     awcache;
        logic [2:0]     awprot;
        logic [3:0]     awqos;
        logic [3:0]     wstrb;
        logic           wlast;
        logic           awvalid;
        logic           wvalid;
        logic           bready;
        logic           bvalid;
        logic [1:0]     bresp;
        logic           busy;
        logic           done;
        logic           error;

        // Slave model and logger
        int             aw_cnt;
        int             w_cnt;
        int             b_cnt;
        int             done_cnt;
        logic           done_q;
        logic           done_long;
        logic           aw_seen;
        logic           w_seen;
        logic [IDW-1:0] id_q;
        logic [31:0]    log_addr [8];
        logic [31:0]    log_data [8];
        logic [3:0]     log_id   [8];

        axi_write_sequencer #(
            .NUM_WRITES    (3),
            .ADDR_WIDTH    (32),
            .DATA_WIDTH    (32),
            .ID_WIDTH      (IDW),
            .STOP_ON_ERROR (SOE)
        ) u_dut (
            .m00_axi_aclk         (clk),
            .m00_axi_aresetn      (rst_n),
            .m00_axi_init_axi_txn (init),
            .seq_addr             (seq_addr),
            .seq_data             (seq_data),
            .seq_count            (seq_count),
            .m00_axi_awid         (awid),
            .m00_axi_awaddr       (awaddr),
            .m00_axi_awvalid      (awvalid),
            .m00_axi_awlen        (awlen),
            .m00_axi_awsize       (awsize),
            .m00_axi_awburst      (awburst),
            .m00_axi_awlock       (awlock),
            .m00_axi_awcache      (awcache),
            .m00_axi_awprot       (awprot),
            .m00_axi_awqos        (awqos),
            .m00_axi_awready      (awready),
            .m00_axi_wdata        (wdata),
            .m00_axi_wstrb        (wstrb),
            .m00_axi_wlast        (wlast),
            .m00_axi_wvalid       (wvalid),
            .m00_axi_wready       (wready),
            .m00_axi_bid          (bid),
            .m00_axi_bresp        (bresp),
            .m00_axi_bvalid       (bvalid),
            .m00_axi_bready       (bready),
            .busy                 (busy),
            .done                 (done),
            .error                (error)
        );

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                aw_cnt    <= 0;
                w_cnt     <= 0;
                b_cnt     <= 0;
                done_cnt  <= 0;
                done_q    <= 1'b0;
                done_long <= 1'b0;
                aw_seen   <= 1'b0;
                w_seen    <= 1'b0;
                id_q      <= '0;
                bvalid    <= 1'b0;
                bid       <= '0;
                bresp     <= 2'b00;
            end else begin
                done_q <= done;
                if (done) done_cnt <= done_cnt + 1;
                if (done && done_q) done_long <= 1'b1;
                if (awvalid && awready) begin
                    aw_seen              <= 1'b1;
                    id_q                 <= awid;
                    log_addr[aw_cnt % 8] <= awaddr;
                    log_id[aw_cnt % 8]   <= 4'(awid);
                    aw_cnt               <= aw_cnt + 1;
                end
                if (wvalid && wready) begin
                    w_seen              <= 1'b1;
                    log_data[w_cnt % 8] <= wdata;
                    w_cnt               <= w_cnt + 1;
                end
                if (aw_seen && w_seen && !bvalid) begin
                    bvalid  <= 1'b1;
                    bid     <= id_q;
                    bresp   <= (b_cnt == bad_entry) ? 2'b10 : 2'b00;
                    aw_seen <= 1'b0;
                    w_seen  <= 1'b0;
                end
                if (bvalid && bready) begin
                    bvalid <= 1'b0;
                    b_cnt  <= b_cnt + 1;
                end
            end
        end
    end

    function automatic int done_cnt_of(input int k);
        case (k)
            0:       return g_dut[0].done_cnt;
            1:       return g_dut[1].done_cnt;
            default: return g_dut[2].done_cnt;
        endcase
    endfunction

    task automatic wait_done(input int k, input int budget);
        int c;
        c = 0;
        while (done_cnt_of(k) == 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (done_cnt_of(k) == 0) begin
            n_fail++;
            $display("FAIL done_timeout dut%0d: no done pulse within %0d cycles, expected one", k, budget);
        end
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst_n   = 1'b0;
        init    = 1'b0;
        awready = 1'b1;
        wready  = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_init;
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        init  = 1'b1;
        #1;
        n_checks++;
        if ({g_dut[0].awvalid, g_dut[0].wvalid, g_dut[0].bready, g_dut[0].busy, g_dut[0].done, g_dut[0].error} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000", {g_dut[0].awvalid, g_dut[0].wvalid, g_dut[0].bready, g_dut[0].busy, g_dut[0].done, g_dut[0].error});
        end
        n_checks++;
        if ({g_dut[0].awaddr, g_dut[0].wdata, g_dut[0].awid} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_payload: got %h expected 0", {g_dut[0].awaddr, g_dut[0].wdata, g_dut[0].awid});
        end
        // Request held high across reset release must not start a sequence
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (g_dut[0].busy !== 1'b0 || g_dut[0].aw_cnt != 0) begin
            n_fail++;
            $display("FAIL init_held_at_release: busy=%b aw=%0d expected busy=0 aw=0", g_dut[0].busy, g_dut[0].aw_cnt);
        end
        init = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        apply_reset();
        seq_count = 2'd3;
        bad_entry = 99;
        pulse_init();
        n_checks++;
        if ({g_dut[0].busy, g_dut[0].awvalid, g_dut[0].wvalid, g_dut[0].awaddr, g_dut[0].wdata, g_dut[0].awid} !== {3'b111, 32'hE000A204, 32'h0000FE01, 4'd0}) begin
            n_fail++;
            $display("FAIL first_issue: got %b%b%b %h %h %h expected 111 e000a204 0000fe01 0",
                     g_dut[0].busy, g_dut[0].awvalid, g_dut[0].wvalid, g_dut[0].awaddr, g_dut[0].wdata, g_dut[0].awid);
        end
        wait_done(0, 100);
        wait_done(2, 100);
        repeat (3) @(negedge clk);
        n_checks++;
        if (g_dut[0].aw_cnt != 3 || g_dut[0].w_cnt != 3 || g_dut[0].b_cnt != 3) begin
            n_fail++;
            $display("FAIL basic_counts: aw=%0d w=%0d b=%0d expected 3 3 3", g_dut[0].aw_cnt, g_dut[0].w_cnt, g_dut[0].b_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (g_dut[0].log_addr[i] !== exp_addr[i] || g_dut[0].log_data[i] !== exp_data[i] || g_dut[0].log_id[i] !== 4'(i)) begin
                n_fail++;
                $display("FAIL basic_entry%0d: got %h %h id %0d expected %h %h id %0d",
                         i, g_dut[0].log_addr[i], g_dut[0].log_data[i], g_dut[0].log_id[i], exp_addr[i], exp_data[i], i);
            end
            n_checks++;
            if (g_dut[2].log_id[i] !== 4'(i % 2)) begin
                n_fail++;
                $display("FAIL id1_awid%0d: got %0d expected %0d", i, g_dut[2].log_id[i], i % 2);
            end
        end
        n_checks++;
        if (g_dut[0].error !== 1'b0 || g_dut[2].error !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_error: got %b/%b expected 0/0", g_dut[0].error, g_dut[2].error);
        end
        n_checks++;
        if (g_dut[0].done_cnt != 1 || g_dut[0].done_long !== 1'b0 || g_dut[0].busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: cnt=%0d long=%b busy=%b expected 1 0 0", g_dut[0].done_cnt, g_dut[0].done_long, g_dut[0].busy);
        end
        n_checks++;
        if ({g_dut[0].awlen, g_dut[0].awsize, g_dut[0].awburst, g_dut[0].awlock, g_dut[0].awcache, g_dut[0].awprot, g_dut[0].awqos, g_dut[0].wstrb, g_dut[0].wlast}
            !== {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0, 4'hF, 1'b1}) begin
            n_fail++;
            $display("FAIL sideband: len=%h size=%0d burst=%b cache=%b strb=%h last=%b expected 00 2 01 0011 f 1",
                     g_dut[0].awlen, g_dut[0].awsize, g_dut[0].awburst, g_dut[0].awcache, g_dut[0].wstrb, g_dut[0].wlast);
        end
    endtask

    task automatic test_aw_delay;
        int   hold;
        logic prev_awv;
        logic prev_rdy;
        logic [31:0] prev_addr;
        bit   split;
        bit   unstable;
        bit   early_drop;
        apply_reset();
        seq_count  = 2'd3;
        bad_entry  = 99;
        awready    = 1'b0;
        hold       = 0;
        prev_awv   = 1'b0;
        prev_rdy   = 1'b0;
        prev_addr  = '0;
        split      = 0;
        unstable   = 0;
        early_drop = 0;
        pulse_init();
        for (int c = 0; c < 300 && g_dut[0].done_cnt == 0; c++) begin
            @(negedge clk);
            if (prev_awv && !prev_rdy && !g_dut[0].awvalid) early_drop = 1;
            if (g_dut[0].awvalid) begin
                if (prev_awv && !prev_rdy && g_dut[0].awaddr !== prev_addr) unstable = 1;
                if (!g_dut[0].wvalid) split = 1;
                hold++;
            end else begin
                hold = 0;
            end
            prev_addr = g_dut[0].awaddr;
            prev_awv  = g_dut[0].awvalid;
            awready   = (hold >= 5);
            prev_rdy  = awready;
        end
        n_checks++;
        if (g_dut[0].done_cnt == 0) begin
            n_fail++;
            $display("FAIL awdelay_done: no done pulse, expected one");
        end
        n_checks++;
        if (!split || unstable || early_drop) begin
            n_fail++;
            $display("FAIL awdelay_order: wfirst=%0d unstable=%0d early=%0d expected 1 0 0", split, unstable, early_drop);
        end
        n_checks++;
        if (g_dut[0].aw_cnt != 3 || g_dut[0].b_cnt != 3 || g_dut[0].log_addr[2] !== exp_addr[2] || g_dut[0].error !== 1'b0) begin
            n_fail++;
            $display("FAIL awdelay_counts: aw=%0d b=%0d addr2=%h err=%b expected 3 3 %h 0",
                     g_dut[0].aw_cnt, g_dut[0].b_cnt, g_dut[0].log_addr[2], g_dut[0].error, exp_addr[2]);
        end
    endtask

    task automatic test_error;
        apply_reset();
        seq_count = 2'd3;
        bad_entry = 1;
        pulse_init();
        wait_done(0, 100);
        wait_done(1, 100);
        repeat (5) @(negedge clk);
        n_checks++;
        if (g_dut[0].error !== 1'b1 || g_dut[0].aw_cnt != 2 || g_dut[0].b_cnt != 2) begin
            n_fail++;
            $display("FAIL stop_on_error: err=%b aw=%0d b=%0d expected 1 2 2", g_dut[0].error, g_dut[0].aw_cnt, g_dut[0].b_cnt);
        end
        n_checks++;
        if (g_dut[1].error !== 1'b1 || g_dut[1].aw_cnt != 3 || g_dut[1].b_cnt != 3) begin
            n_fail++;
            $display("FAIL continue_on_error: err=%b aw=%0d b=%0d expected 1 3 3", g_dut[1].error, g_dut[1].aw_cnt, g_dut[1].b_cnt);
        end
        bad_entry = 99;
    endtask

    task automatic test_count_edges;
        int first_done;
        apply_reset();
        seq_count  = 2'd0;
        first_done = -1;
        @(negedge clk);
        init = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            init = 1'b0;
            if (g_dut[0].done === 1'b1 && first_done < 0) first_done = k;
        end
        n_checks++;
        if (first_done != 2 || g_dut[0].aw_cnt != 0) begin
            n_fail++;
            $display("FAIL count0: done at cycle %0d aw=%0d expected cycle 2 aw=0", first_done, g_dut[0].aw_cnt);
        end
        // 2-bit count port: largest encodable request
        apply_reset();
        seq_count = 2'(7);
        pulse_init();
        wait_done(0, 100);
        repeat (3) @(negedge clk);
        n_checks++;
        if (g_dut[0].aw_cnt != 3 || g_dut[0].b_cnt != 3) begin
            n_fail++;
            $display("FAIL count_max: aw=%0d b=%0d expected 3 3", g_dut[0].aw_cnt, g_dut[0].b_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int c;
        apply_reset();
        seq_count = 2'd3;
        pulse_init();
        c = 0;
        while (g_dut[0].aw_cnt < 2 && c < 100) begin
            @(negedge clk);
            c++;
        end
        awready = 1'b0;
        c = 0;
        while (!(g_dut[0].awvalid === 1'b1 && g_dut[0].aw_cnt == 2) && c < 100) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (g_dut[0].awvalid !== 1'b1 || g_dut[0].awaddr !== exp_addr[2]) begin
            n_fail++;
            $display("FAIL midreset_setup: awvalid=%b addr=%h expected 1 %h", g_dut[0].awvalid, g_dut[0].awaddr, exp_addr[2]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({g_dut[0].awvalid, g_dut[0].wvalid, g_dut[0].bready, g_dut[0].busy, g_dut[0].awaddr} !== 36'h0) begin
            n_fail++;
            $display("FAIL midreset_async: got %b%b%b%b %h expected 0000 0",
                     g_dut[0].awvalid, g_dut[0].wvalid, g_dut[0].bready, g_dut[0].busy, g_dut[0].awaddr);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        awready = 1'b1;
        @(negedge clk);
        pulse_init();
        wait_done(0, 100);
        n_checks++;
        if (g_dut[0].log_addr[0] !== exp_addr[0] || g_dut[0].log_id[0] !== 4'd0 || g_dut[0].aw_cnt != 3) begin
            n_fail++;
            $display("FAIL midreset_restart: addr0=%h id0=%0d aw=%0d expected %h 0 3",
                     g_dut[0].log_addr[0], g_dut[0].log_id[0], g_dut[0].aw_cnt, exp_addr[0]);
        end
    endtask

    initial begin
        exp_addr[0] = 32'hE000A204; exp_data[0] = 32'h0000FE01;
        exp_addr[1] = 32'hE000A208; exp_data[1] = 32'h0000FE01;
        exp_addr[2] = 32'hE000A040; exp_data[2] = 32'h00000001;
        seq_addr  = {exp_addr[2], exp_addr[1], exp_addr[0]};
        seq_data  = {exp_data[2], exp_data[1], exp_data[0]};
        seq_count = 2'd3;
        bad_entry = 99;
        rst_n     = 1'b0;
        init      = 1'b0;
        awready   = 1'b1;
        wready    = 1'b1;

        test_reset();
        test_basic();
        test_aw_delay();
        test_error();
        test_count_edges();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
